// File: rtl/snn_io_ctrl.sv
// snn_io_ctrl: sequencer between the UART pair and the SNN core.
// Unpacks received bytes LSB-first into the 1-bit input RAM, starts the core,
// returns the classified digit over uart_tx and mirrors status on the LEDs.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_RECV      | idle, waiting for the next image byte from uart_rx
// S_UNPACK    | writing the 8 bits of the current byte, one per cycle
// S_START     | core_start high for this single cycle
// S_WAIT_CORE | waiting for core_done with the classified digit
// S_SEND      | waiting for tx_rdy, then requesting the transmit
// S_WAIT_TX   | waiting for uart_tx to go busy and back to idle
module snn_io_ctrl #(
   parameter int NUM_PIXELS = 784,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_rdy,
   input  logic [7:0]            rx_data,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_wdata,
   output logic                  core_start,
   input  logic                  core_done,
   input  logic [3:0]            core_digit,
   output logic                  tx_start,
   output logic [7:0]            tx_data,
   input  logic                  tx_rdy,
   output logic [7:0]            led
);

   typedef enum logic [2:0] {
      S_RECV,
      S_UNPACK,
      S_START,
      S_WAIT_CORE,
      S_SEND,
      S_WAIT_TX
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] END_ADDR = ADDR_WIDTH'(NUM_PIXELS);
   localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

   state_t                state_q,      state_d;
   logic [7:0]            shift_q,      shift_d;
   logic [2:0]            bit_idx_q,    bit_idx_d;
   logic [ADDR_WIDTH-1:0] addr_cnt_q,   addr_cnt_d;
   logic [7:0]            pend_q,       pend_d;
   logic                  pend_full_q,  pend_full_d;
   logic                  ovr_q,        ovr_d;
   logic [3:0]            digit_q,      digit_d;
   logic                  seen_low_q,   seen_low_d;
   logic                  ram_we_q,     ram_we_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q,   ram_addr_d;
   logic                  ram_wdata_q,  ram_wdata_d;
   logic                  core_start_q, core_start_d;
   logic                  tx_start_q,   tx_start_d;
   logic [7:0]            tx_data_q,    tx_data_d;
   logic [7:0]            led_q,        led_d;
   logic [7:0]            next_byte;

   // Next-state, datapath and registered-output computation.
   // bit_idx holds the index of the next bit to write; it wraps to 0 on the
   // cycle carrying the 8th write of a byte, which is where the byte-end
   // decision is taken so a follow-on byte can begin without an idle cycle.
   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_idx_d    = bit_idx_q;
      addr_cnt_d   = addr_cnt_q;
      pend_d       = pend_q;
      pend_full_d  = pend_full_q;
      ovr_d        = ovr_q;
      digit_d      = digit_q;
      seen_low_d   = seen_low_q;
      ram_we_d     = 1'b0;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      core_start_d = 1'b0;
      tx_start_d   = 1'b0;
      tx_data_d    = tx_data_q;
      next_byte    = pend_full_q ? pend_q : rx_data;

      case (state_q)
         S_RECV: begin
            if (rx_rdy) begin
               state_d     = S_UNPACK;
               shift_d     = rx_data;
               ram_we_d    = 1'b1;
               ram_addr_d  = addr_cnt_q;
               ram_wdata_d = rx_data[0];
               bit_idx_d   = 3'd1;
               addr_cnt_d  = addr_cnt_q + ONE;
            end
         end

         S_UNPACK: begin
            if (bit_idx_q != 3'd0) begin
               ram_we_d    = 1'b1;
               ram_addr_d  = addr_cnt_q;
               ram_wdata_d = shift_q[bit_idx_q];
               bit_idx_d   = bit_idx_q + 3'd1;
               addr_cnt_d  = addr_cnt_q + ONE;
               if (rx_rdy) begin
                  if (pend_full_q) begin
                     ovr_d = 1'b1;
                  end else begin
                     pend_d      = rx_data;
                     pend_full_d = 1'b1;
                  end
               end
            end else if (addr_cnt_q == END_ADDR) begin
               // Image complete: anything buffered belongs to no image.
               state_d      = S_START;
               core_start_d = 1'b1;
               pend_full_d  = 1'b0;
               if (pend_full_q || rx_rdy) begin
                  ovr_d = 1'b1;
               end
            end else if (pend_full_q || rx_rdy) begin
               // Back-to-back byte: the buffered one goes first, and a byte
               // arriving now takes its freed slot.
               shift_d     = next_byte;
               ram_we_d    = 1'b1;
               ram_addr_d  = addr_cnt_q;
               ram_wdata_d = next_byte[0];
               bit_idx_d   = 3'd1;
               addr_cnt_d  = addr_cnt_q + ONE;
               if (pend_full_q && rx_rdy) begin
                  pend_d = rx_data;
               end else begin
                  pend_full_d = 1'b0;
               end
            end else begin
               state_d = S_RECV;
            end
         end

         S_START: begin
            state_d = S_WAIT_CORE;
            if (rx_rdy) begin
               ovr_d = 1'b1;
            end
         end

         S_WAIT_CORE: begin
            if (rx_rdy) begin
               ovr_d = 1'b1;
            end
            if (core_done) begin
               digit_d   = core_digit;
               tx_data_d = {4'h0, core_digit};
               state_d   = S_SEND;
            end
         end

         S_SEND: begin
            if (rx_rdy) begin
               ovr_d = 1'b1;
            end
            if (tx_rdy) begin
               tx_start_d = 1'b1;
               seen_low_d = 1'b0;
               state_d    = S_WAIT_TX;
            end
         end

         S_WAIT_TX: begin
            if (rx_rdy) begin
               ovr_d = 1'b1;
            end
            if (!tx_rdy) begin
               seen_low_d = 1'b1;
            end else if (seen_low_q) begin
               state_d    = S_RECV;
               addr_cnt_d = '0;
            end
         end

         default: begin
            state_d = S_RECV;
         end
      endcase

      led_d = {ovr_d, (state_d != S_RECV), 2'b00, digit_d};
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_RECV;
         shift_q      <= '0;
         bit_idx_q    <= '0;
         addr_cnt_q   <= '0;
         pend_q       <= '0;
         pend_full_q  <= 1'b0;
         ovr_q        <= 1'b0;
         digit_q      <= '0;
         seen_low_q   <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= 1'b0;
         core_start_q <= 1'b0;
         tx_start_q   <= 1'b0;
         tx_data_q    <= '0;
         led_q        <= '0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bit_idx_q    <= bit_idx_d;
         addr_cnt_q   <= addr_cnt_d;
         pend_q       <= pend_d;
         pend_full_q  <= pend_full_d;
         ovr_q        <= ovr_d;
         digit_q      <= digit_d;
         seen_low_q   <= seen_low_d;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         core_start_q <= core_start_d;
         tx_start_q   <= tx_start_d;
         tx_data_q    <= tx_data_d;
         led_q        <= led_d;
      end
   end

   assign ram_we     = ram_we_q;
   assign ram_addr   = ram_addr_q;
   assign ram_wdata  = ram_wdata_q;
   assign core_start = core_start_q;
   assign tx_start   = tx_start_q;
   assign tx_data    = tx_data_q;
   assign led        = led_q;

endmodule
